// File: rtl/fec_pkg.sv
// fec_pkg: shared constants, types and state encoding for the FEC datapath.
// Contents:
//   FEC_M       symbols per encoded block
//   FEC_WIDTH   encoded symbol width including the parity bit
//   FEC_DATA_W  payload bits per symbol once parity is dropped
//   FEC_SEQ_W   width of the per-block sequence tag
//   fec_data_t, fec_seq_t, fec_ser_state_e
package fec_pkg;

  localparam int FEC_M      = 3;
  localparam int FEC_WIDTH  = 11;
  localparam int FEC_DATA_W = FEC_WIDTH - 1;
  localparam int FEC_SEQ_W  = 4;

  typedef logic [FEC_DATA_W-1:0] fec_data_t;
  typedef logic [FEC_SEQ_W-1:0]  fec_seq_t;

  // Serializer either holds nothing or is presenting one beat of a block
  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } fec_ser_state_e;

endpackage

// File: rtl/fec_symbol_serializer.sv
// fec_symbol_serializer: captures a block of M encoded data words in parallel
// and streams them out one word per beat, index 0 first, tagged with a
// per-block sequence number and first/last markers.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   in_valid/in_ready block handshake; in_symbols carries the M words
//   out_valid/out_ready beat handshake (outputs hold while stalled)
//   out_data          current word
//   out_idx           word index within the block
//   out_first/out_last markers for index 0 and index M-1
//   out_seq           sequence tag of the block being sent
//   busy              a block is held
module fec_symbol_serializer
  import fec_pkg::*;
#(
  parameter int M      = FEC_M,
  parameter int WIDTH  = FEC_WIDTH,
  parameter int DATA_W = WIDTH - 1,
  parameter int SEQ_W  = FEC_SEQ_W,
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_symbols [M],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_first,
  output logic              out_last,
  output logic [SEQ_W-1:0]  out_seq,
  output logic              busy
);

  fec_ser_state_e    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEQ_W-1:0]  seq_cnt_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [DATA_W-1:0] buf_q [M];

  logic sending;
  logic is_last;
  logic beat_acc;
  logic accept;

  assign sending  = (state_q == SER_SEND);
  assign is_last  = (idx_q == IDX_W'(M - 1));
  assign beat_acc = sending && out_ready;

  // Accepting a new block on the same edge the last beat leaves is what gives
  // zero-bubble back-to-back blocks; out_ready is the only input feeding in_ready.
  assign in_ready = (state_q == SER_IDLE) || (beat_acc && is_last);
  assign accept   = in_valid && in_ready;

  // Next-state and index logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      SER_IDLE: begin
        if (accept) begin
          state_d = SER_SEND;
          idx_d   = '0;
        end
      end
      SER_SEND: begin
        if (beat_acc) begin
          if (is_last) begin
            idx_d   = '0;
            state_d = in_valid ? SER_SEND : SER_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = SER_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and beat index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Block buffer and sequence tags; only an accepted block touches them, so
  // in_symbols is ignored while a block is being sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt_q <= '0;
      seq_q     <= '0;
      for (int i = 0; i < M; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      seq_q     <= seq_cnt_q;
      seq_cnt_q <= seq_cnt_q + SEQ_W'(1);
      for (int i = 0; i < M; i++) begin
        buf_q[i] <= in_symbols[i];
      end
    end
  end

  // Word select by index; written as a compare loop so M=1 needs no special case
  always_comb begin
    out_data = '0;
    for (int i = 0; i < M; i++) begin
      if (idx_q == IDX_W'(i)) begin
        out_data = buf_q[i];
      end
    end
  end

  assign out_valid = sending;
  assign out_idx   = idx_q;
  assign out_first = sending && (idx_q == '0);
  assign out_last  = sending && is_last;
  assign out_seq   = seq_q;
  assign busy      = sending;

endmodule

// File: tb/tb_fec_symbol_serializer.sv
// tb_fec_symbol_serializer: scoreboard bench for fec_symbol_serializer.
// Main instance uses M=3; a second M=1 instance covers the single-symbol build.
module tb_fec_symbol_serializer;

  typedef struct packed {
    logic [9:0] data;
    logic [1:0] idx;
    logic       first;
    logic       last;
    logic [3:0] seq;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_symbols [3];
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [1:0] out_idx;
  logic       out_first;
  logic       out_last;
  logic [3:0] out_seq;
  logic       busy;

  logic       in_valid1;
  logic       in_ready1;
  logic [9:0] in_symbols1 [1];
  logic       out_valid1;
  logic       out_ready1;
  logic [9:0] out_data1;
  logic [0:0] out_idx1;
  logic       out_first1;
  logic       out_last1;
  logic [3:0] out_seq1;
  logic       busy1;

  int         n_checks;
  int         n_fail;
  beat_t      sb[$];
  logic [3:0] exp_seq;
  bit         mon_en;
  bit         bp_en;
  int         bp_cnt;

  fec_symbol_serializer #(.M(3), .WIDTH(11), .SEQ_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_symbols(in_symbols),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_first(out_first), .out_last(out_last),
    .out_seq(out_seq), .busy(busy)
  );

  fec_symbol_serializer #(.M(1), .WIDTH(11), .SEQ_W(4)) dut_m1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_symbols(in_symbols1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_idx(out_idx1), .out_first(out_first1), .out_last(out_last1),
    .out_seq(out_seq1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one block, wait for acceptance, then queue its expected beats
  task automatic applyStimulus(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
    bit done;
    done = 0;
    @(negedge clk);
    in_symbols[0] = s0;
    in_symbols[1] = s1;
    in_symbols[2] = s2;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
    checkOutput("block_accepted", done, 1);
    if (done) begin
      sb.push_back(beat_t'{data: s0, idx: 2'd0, first: 1'b1, last: 1'b0, seq: exp_seq});
      sb.push_back(beat_t'{data: s1, idx: 2'd1, first: 1'b0, last: 1'b0, seq: exp_seq});
      sb.push_back(beat_t'{data: s2, idx: 2'd2, first: 1'b0, last: 1'b1, seq: exp_seq});
      exp_seq = exp_seq + 4'd1;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && (sb.size() != 0 || out_valid); i++) begin
      @(negedge clk);
    end
    checkOutput("drained", {31'(sb.size() != 0), out_valid}, 0);
  endtask

  task automatic resetDut();
    mon_en = 0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq = 4'd0;
    mon_en = 1;
  endtask

  // Downstream ready: always ready, or a 1,0,0 repeating stall pattern
  initial begin
    out_ready = 1'b1;
    bp_cnt = 0;
    forever begin
      @(negedge clk);
      if (bp_en) begin
        out_ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: any presented beat must equal the head of the scoreboard; it is
  // popped only once the downstream takes it, so stalled beats must hold.
  initial begin
    logic  exp_ir;
    beat_t got;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        exp_ir = (sb.size() == 0) ? 1'b1 : (sb[0].last && out_ready);
        checkOutput("in_ready", in_ready, exp_ir);
        if (sb.size() != 0) begin
          checkOutput("out_valid", out_valid, 1);
          if (out_valid) begin
            got = {out_data, out_idx, out_first, out_last, out_seq};
            checkOutput("beat", got, sb[0]);
            if (out_ready) void'(sb.pop_front());
          end
        end else begin
          checkOutput("out_valid_idle", out_valid, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_seq = 4'd0;
    mon_en = 0;
    bp_en = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    in_symbols1[0] = '0;
    for (int i = 0; i < 3; i++) in_symbols[i] = '0;

    // Reset values
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    checkOutput("rst_out_seq", out_seq, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_first_last", {out_first, out_last}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;

    $display("[TB] single block");
    applyStimulus(10'h3A5, 10'h001, 10'h2FF);
    waitDrain();
    checkOutput("idle_in_ready", in_ready, 1);

    $display("[TB] back-to-back blocks");
    applyStimulus(10'h101, 10'h102, 10'h103);
    applyStimulus(10'h201, 10'h202, 10'h203);
    applyStimulus(10'h301, 10'h302, 10'h303);
    waitDrain();

    $display("[TB] backpressure");
    bp_cnt = 0;
    bp_en = 1;
    applyStimulus(10'h111, 10'h222, 10'h333);
    @(negedge clk);
    in_symbols[0] = 10'h3FF;
    in_symbols[1] = 10'h3FE;
    in_symbols[2] = 10'h3FD;
    waitDrain();
    bp_en = 0;

    $display("[TB] reset mid-block");
    applyStimulus(10'h0AA, 10'h0BB, 10'h0CC);
    @(posedge clk);
    @(posedge clk);
    #2;
    mon_en = 0;
    sb.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_idx", out_idx, 0);
    checkOutput("midrst_out_seq", out_seq, 0);
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq = 4'd0;
    mon_en = 1;
    applyStimulus(10'h123, 10'h045, 10'h067);
    waitDrain();

    $display("[TB] sequence wrap");
    resetDut();
    for (int b = 0; b < 17; b++) begin
      applyStimulus(10'(b * 3), 10'(b * 3 + 1), 10'(b * 3 + 2));
    end
    waitDrain();

    $display("[TB] M=1 build");
    @(negedge clk);
    in_symbols1[0] = 10'h155;
    in_valid1 = 1'b1;
    #1;
    checkOutput("m1_in_ready_idle", in_ready1, 1);
    @(posedge clk);
    @(negedge clk);
    in_symbols1[0] = 10'h2AA;
    #1;
    checkOutput("m1_beat0", {out_valid1, out_data1, out_idx1, out_first1, out_last1, out_seq1},
                {1'b1, 10'h155, 1'b0, 1'b1, 1'b1, 4'd0});
    checkOutput("m1_in_ready_last", in_ready1, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    #1;
    checkOutput("m1_beat1", {out_valid1, out_data1, out_idx1, out_first1, out_last1, out_seq1},
                {1'b1, 10'h2AA, 1'b0, 1'b1, 1'b1, 4'd1});
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("m1_idle_valid", out_valid1, 0);
    checkOutput("m1_idle_ready", in_ready1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
